simple_module_checker: RTL and testbench

- Synthesizable self-test engine for the 2-input `simple_module` family. It drives the `a`/`b` stimulus and receives the `y` response.
- Per pass, it sweeps all four input vectors in order 00, 01, 10, 11. Each vector is held for a settle interval, then `y` is sampled and compared against a parameterized truth table.
- Reports a per-vector fail mask, a saturating error count and pass/done status.
- Sits beside the DUT on-chip, so hardware can repeat the bench's check without a simulator.

---
 rtl/simple_module_checker.sv | 174 +++++++++++++++++
 tb/tb_simple_module_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/simple_module_checker.sv
// simple_module_checker
// On-chip self-test engine for the 2-input simple_module family. Each run
// sweeps the input vectors {a,b} = 00, 01, 10, 11 for NUM_PASSES passes.
// Every vector is held for SETTLE_CYCLES cycles and then y_in is sampled and
// compared against the golden truth table EXPECTED[{a,b}].
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a run (accepted in IDLE or DONE only; wins over abort)
//   abort      terminate a run in progress (partial results are kept)
//   y_in       response of the device under test
//   a_out      registered stimulus a
//   b_out      registered stimulus b
//   busy       high while sweeping (SETTLE or SAMPLE)
//   done       high in DONE, held until start or rst
//   pass       high in DONE when no mismatch was seen
//   fail_mask  bit i set if vector i mismatched in any pass
//   err_count  total mismatches, saturating at 255
module simple_module_checker #(
  parameter logic [3:0] EXPECTED      = 4'b1000,
  parameter int         SETTLE_CYCLES = 10,
  parameter int         NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [7:0] CNT_INIT  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_PASS = 8'(NUM_PASSES - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic [7:0] err_count_q, err_count_d;
  logic       mismatch;

  // Saturating increment: the error counter sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_cnt_d  = pass_cnt_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    err_count_d = err_count_q;
    mismatch    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // start wins over abort here; abort alone has no effect
        if (start) begin
          fail_mask_d = 4'b0000;
          err_count_d = 8'd0;
          pass_d      = 1'b0;
          idx_d       = 2'd0;
          pass_cnt_d  = 8'd0;
          cnt_d       = CNT_INIT;
          a_d         = 1'b0;
          b_d         = 1'b0;
          state_d     = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        // The mismatch is recorded even when abort arrives in this cycle.
        mismatch = (y_in != EXPECTED[idx_q]);
        if (mismatch) begin
          fail_mask_d[idx_q] = 1'b1;
          err_count_d        = sat_inc(err_count_q);
        end
        if (abort) begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (idx_q == 2'd3 && pass_cnt_q == LAST_PASS) begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (err_count_d == 8'd0);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            pass_cnt_d = pass_cnt_q + 8'd1;
          end
          cnt_d   = CNT_INIT;
          a_d     = idx_d[1];
          b_d     = idx_d[0];
          state_d = S_SETTLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      pass_cnt_q  <= 8'd0;
      cnt_q       <= 8'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'b0000;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_cnt_q  <= pass_cnt_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      err_count_q <= err_count_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_simple_module_checker.sv
module tb_simple_module_checker;

  localparam logic [3:0] EXP = 4'b1000;
  localparam int SP[3] = '{10, 10, 1};
  localparam int PP[3] = '{1, 3, 100};

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s   [3];
  logic       abort_s   [3];
  logic [3:0] tt_v      [3];
  logic       y_w       [3];
  logic       a_w       [3];
  logic       b_w       [3];
  logic       busy_w    [3];
  logic       done_w    [3];
  logic       pass_w    [3];
  logic [3:0] fm_w      [3];
  logic [7:0] err_w     [3];

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    simple_module_checker #(
      .EXPECTED     (EXP),
      .SETTLE_CYCLES(SP[g]),
      .NUM_PASSES   (PP[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s[g]),
      .abort    (abort_s[g]),
      .y_in     (y_w[g]),
      .a_out    (a_w[g]),
      .b_out    (b_w[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .pass     (pass_w[g]),
      .fail_mask(fm_w[g]),
      .err_count(err_w[g])
    );
    // Behavioural 2-input gate under test, described by its truth table
    assign y_w[g] = tt_v[g][{a_w[g], b_w[g]}];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the first n sampled vectors cycle 0,1,2,3,0,...; each one whose
  // gate output differs from the golden table sets its mask bit and bumps a
  // counter clamped at 255.
  function automatic void model(input logic [3:0] tt, input int n,
                                output logic [3:0] fm, output int err);
    fm  = 4'b0000;
    err = 0;
    for (int m = 0; m < n; m++) begin
      if (tt[m % 4] !== EXP[m % 4]) begin
        fm[m % 4] = 1'b1;
        if (err < 255) err++;
      end
    end
  endfunction

  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("%s.busy", tag), 32'(busy_w[k]), 0);
    chk($sformatf("%s.done", tag), 32'(done_w[k]), 0);
    chk($sformatf("%s.pass", tag), 32'(pass_w[k]), 0);
    chk($sformatf("%s.ab", tag), 32'({a_w[k], b_w[k]}), 0);
  endtask

  // One run on instance k. mid_j/abort_j/rst_j give the cycle (counted from
  // the accepting edge) at which that input is pulsed; -1 means never.
  task automatic run(input int k, input logic [3:0] tt, input int mid_j,
                     input int abort_j, input int rst_j, input bit both,
                     input string tag);
    int S, P, total, n_samp;
    logic [3:0] fm_e;
    int err_e;
    logic [1:0] v;
    S = SP[k];
    P = PP[k];
    total = P * 4 * (S + 1);
    n_samp = 4 * P;
    tt_v[k] = tt;
    @(negedge clk);
    start_s[k] = 1'b1;
    abort_s[k] = both;
    for (int j = 0; j <= total; j++) begin
      @(negedge clk);
      start_s[k] = 1'b0;
      abort_s[k] = 1'b0;
      if (j < total) begin
        v = 2'((j / (S + 1)) % 4);
        chk($sformatf("%s.busy j=%0d", tag, j), 32'(busy_w[k]), 1);
        chk($sformatf("%s.done j=%0d", tag, j), 32'(done_w[k]), 0);
        chk($sformatf("%s.ab j=%0d", tag, j), 32'({a_w[k], b_w[k]}), 32'(v));
        if (j == 0) begin
          chk($sformatf("%s.clr_fm", tag), 32'(fm_w[k]), 0);
          chk($sformatf("%s.clr_err", tag), 32'(err_w[k]), 0);
          chk($sformatf("%s.clr_pass", tag), 32'(pass_w[k]), 0);
        end
      end else begin
        chk($sformatf("%s.done_at_%0d", tag, total + 1), 32'(done_w[k]), 1);
        chk($sformatf("%s.busy_end", tag), 32'(busy_w[k]), 0);
        chk($sformatf("%s.ab_end", tag), 32'({a_w[k], b_w[k]}), 0);
        break;
      end
      start_s[k] = (j == mid_j);
      if (j == abort_j) begin
        abort_s[k] = 1'b1;
        @(negedge clk);
        abort_s[k] = 1'b0;
        // samples whose edge is at or before the aborting edge are recorded
        n_samp = (j + 1) / (S + 1);
        chk_idle(k, $sformatf("%s.abort", tag));
        model(tt, n_samp, fm_e, err_e);
        chk($sformatf("%s.abort_fm", tag), 32'(fm_w[k]), 32'(fm_e));
        chk($sformatf("%s.abort_err", tag), 32'(err_w[k]), 32'(err_e));
        return;
      end
      if (j == rst_j) begin
        rst = 1'b1;
        @(negedge clk);
        chk_idle(k, $sformatf("%s.rst", tag));
        chk($sformatf("%s.rst_fm", tag), 32'(fm_w[k]), 0);
        chk($sformatf("%s.rst_err", tag), 32'(err_w[k]), 0);
        start_s[k] = 1'b1;
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          chk($sformatf("%s.rst_start_busy r=%0d", tag, r), 32'(busy_w[k]), 0);
          chk($sformatf("%s.rst_start_done r=%0d", tag, r), 32'(done_w[k]), 0);
        end
        start_s[k] = 1'b0;
        rst = 1'b0;
        return;
      end
    end
    model(tt, n_samp, fm_e, err_e);
    chk($sformatf("%s.fm", tag), 32'(fm_w[k]), 32'(fm_e));
    chk($sformatf("%s.err", tag), 32'(err_w[k]), 32'(err_e));
    chk($sformatf("%s.pass", tag), 32'(pass_w[k]), 32'(err_e == 0));
  endtask

  initial begin
    logic [3:0] rtt;
    int rj;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b1;
      abort_s[k] = 1'b0;
      tt_v[k]    = EXP;
    end
    // Reset held with start high keeps every instance idle
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_idle(k, $sformatf("reset%0d", k));
      chk($sformatf("reset%0d.fm", k), 32'(fm_w[k]), 0);
      chk($sformatf("reset%0d.err", k), 32'(err_w[k]), 0);
      start_s[k] = 1'b0;
    end
    rst = 1'b0;

    // Abort while idle does nothing
    @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk_idle(0, "abort_idle");

    run(0, 4'b1000, -1, -1, -1, 1'b0, "and");
    run(0, 4'b0000, -1, -1, -1, 1'b0, "tie0");
    // Abort in DONE leaves the results in place
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk("abort_done.done", 32'(done_w[0]), 1);
    chk("abort_done.fm", 32'(fm_w[0]), 32'(4'b1000));
    run(0, 4'b1110, -1, -1, -1, 1'b0, "or");
    run(0, 4'b1000, 25, -1, -1, 1'b0, "mid_start");
    run(0, 4'b0110, -1, -1, -1, 1'b1, "start_abort");
    for (int i = 0; i < 4; i++) begin
      rtt = 4'($urandom);
      rj  = int'($urandom_range(1, 42));
      run(0, rtt, rj, -1, -1, 1'b0, $sformatf("rand%0d", i));
    end
    run(0, 4'b0111, -1, 14, -1, 1'b0, "abort_v1");
    run(0, 4'b1000, -1, -1, -1, 1'b0, "after_abort");
    run(0, 4'b0000, -1, -1, 43, 1'b0, "rst_sample");
    run(1, 4'b0111, -1, -1, -1, 1'b0, "inv_p3");
    run(2, 4'b0111, -1, -1, -1, 1'b0, "inv_p100");
    rtt = 4'($urandom);
    run(1, rtt, -1, -1, -1, 1'b0, "rand_p3");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
